waveform_scroll: RTL
====================

# waveform_scroll

Scrolling single-trace waveform renderer for the heart-signal display. Keeps the most recent WIDTH samples in an internal circular buffer, oldest at the left and newest at the right. Draws them as a connected trace, with a vertical segment between adjacent columns, from the VGA pixel counters. It succeeds the static per-pixel waveform block: it adds sample history, scrolling, freeze, fill tracking, frame-latched tear-free readout and configurable geometry.

## Interface
- WIDTH, 1024: trace width in columns/buffer depth; power of 2, ≥4
- THICKNESS, 3: extra rows added below each segment
- TOP, 0: screen row for the largest positive sample
- BOTTOM, 512: screen row for sample 0; must be > TOP
- clk  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sample_in  in  9  signed sample, −256..255
- sample_valid  in  1  one-cycle strobe: capture sample_in
- freeze  in  1  high: ignore sample_valid, display holds
- enable  in  1  low: pixel forced 0; writes still accepted
- color  in  12  RGB444 trace colour
- hcount  in  11  current pixel column
- vcount  in  10  current pixel row
- pixel  out  12  RGB444 output, 0 when not lit
- wr_ptr  out  log2(WIDTH)  next buffer write index

## Operation
- Row mapping at write:
  - y = BOTTOM − (((BOTTOM−TOP)·sample_in) >>> 8).
  - Product is signed, at least 22 bits. The shift is arithmetic.
  - Clamp y to [TOP, BOTTOM−1], then store it as 10 bits.
- Write:
  - On sample_valid && !freeze: buf[wr_ptr] ← y and wr_ptr ← wr_ptr+1, wrapping WIDTH−1→0.
  - fill ← min(fill+1, WIDTH).
  - When freeze is high, samples are dropped and not queued.
- Frame latch: at hcount==0 && vcount==0, base ← wr_ptr and fill_f ← fill. The whole frame uses these latched copies.
- Column c < WIDTH reads entry (base + c) mod WIDTH.
  - The column is valid iff c ≥ WIDTH − fill_f, so an unfilled buffer right-aligns its newest data.
  - An invalid column outputs 0.
- Connected trace:
  - y_prev is the previous column's y. For column 0, or the first valid column, y_prev = y_cur.
  - Lit iff min(y_cur,y_prev) ≤ vcount < max(y_cur,y_prev)+THICKNESS.
- hcount ≥ WIDTH or enable low: pixel 0.
- Buffer is read-first: a same-cycle write to the entry being read returns the old value.

## Timing
- Reset (async) state:
  - pixel = 0, wr_ptr = 0, fill = 0, fill_f = 0, base = 0.
  - Buffer contents are don't-care, since fill = 0 masks them.
- Reset asserted mid-frame blanks pixel immediately; the trace restarts empty.
- Read pipeline:
  - Cycle 0: hcount/vcount presented.
  - Cycle 1: buffer data and y_prev available.
  - Cycle 2: pixel registered.
  - Latency is a fixed 2 clocks; the upstream sync path delays by 2 to match.
- Write latency: a sample written in cycle n is visible in the next frame latched after n. It is never visible mid-frame.
- A write and the frame latch in the same cycle: the latch takes the pre-write wr_ptr and fill.
- sample_valid on consecutive cycles: each cycle writes; no back-pressure.
- fill saturates at WIDTH; wr_ptr wraps freely.

## Test plan
- Reset, no samples, WIDTH=8, THICKNESS=1, TOP=0, BOTTOM=512 -> pixel=0 for every hcount/vcount over two frames; wr_ptr=0.
- Write 0,128,−256,255, then frame start -> wr_ptr=4 and columns 0–3 blank.
  - Col 4: y=511, lit row 511 only.
  - Col 5: y=256, lit rows 256..511.
  - Col 6: y=511 (clamped), lit 256..511.
  - Col 7: y=2, lit 2..511.
  - All other rows 0; pixel equals color 2 clocks after the matching hcount/vcount.
- Write 10 samples k=0..9 of value 16·k -> wr_ptr=2, fill=8; column 0 shows sample 2 (y=448), column 7 shows sample 9 (y=224).
- freeze=1 with 5 sample_valid strobes -> wr_ptr and displayed frame unchanged. Release freeze, write 1 sample -> wr_ptr+1.
- Write during active frame -> image identical until next hcount=vcount=0, then shifted one column left.
- enable=0 or hcount≥8 -> pixel=0. Assert reset mid-line -> pixel=0 the same cycle, next frame blank.

Source files
------------

// File: rtl/waveform_scroll.sv
// Scrolling single-trace waveform renderer: circular sample history drawn as a
// connected trace, with a per-frame latched read window so the image never tears.
module waveform_scroll #(
    parameter int WIDTH     = 1024,
    parameter int THICKNESS = 3,
    parameter int TOP       = 0,
    parameter int BOTTOM    = 512,
    localparam int AW       = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [8:0]  sample_in,
    input  logic               sample_valid,
    input  logic               freeze,
    input  logic               enable,
    input  logic [11:0]        color,
    input  logic [10:0]        hcount,
    input  logic [9:0]         vcount,
    output logic [11:0]        pixel,
    output logic [AW-1:0]      wr_ptr
);

    localparam int          SPAN  = BOTTOM - TOP;
    localparam logic [AW:0] DEPTH = (AW+1)'(WIDTH);

    logic [9:0]    mem [WIDTH];
    logic [AW-1:0] base;
    logic [AW:0]   fill;
    logic [AW:0]   fill_f;

    // ------------------------------------------------------------------
    // Write side: map the signed sample to a clamped screen row
    // ------------------------------------------------------------------
    logic signed [31:0] prod;
    logic signed [31:0] y_raw;
    logic [9:0]         y_wr;
    logic               wr_en;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        prod  = SPAN * 32'(sample_in);
        y_raw = BOTTOM - (prod >>> 8);
        if (y_raw < TOP)
            y_wr = 10'(TOP);
        else if (y_raw > BOTTOM - 1)
            y_wr = 10'(BOTTOM - 1);
        else
            y_wr = y_raw[9:0];
        wr_en = sample_valid && !freeze;
    end

    // At frame start the latch and the first read of the frame share a cycle,
    // so the read uses the values being latched rather than the stale copy.
    logic          frame_start;
    logic [AW-1:0] base_rd;
    logic [AW:0]   fill_rd;
    logic [AW:0]   thresh;
    logic [AW-1:0] col;
    logic          in_range;
    logic          cur_valid;
    logic          prev_valid;
    logic [AW-1:0] addr_cur;
    logic [AW-1:0] addr_prev;

    always_comb begin
        frame_start = (hcount == '0) && (vcount == '0);
        base_rd     = frame_start ? wr_ptr : base;
        fill_rd     = frame_start ? fill : fill_f;
        thresh      = DEPTH - fill_rd;
        col         = hcount[AW-1:0];
        in_range    = int'(hcount) < WIDTH;
        cur_valid   = in_range && ({1'b0, col} >= thresh);
        prev_valid  = (col != '0) && ({1'b0, col} > thresh);
        addr_cur    = base_rd + col;
        addr_prev   = addr_cur - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            fill   <= '0;
            base   <= '0;
            fill_f <= '0;
        end else begin
            if (frame_start) begin
                base   <= wr_ptr;
                fill_f <= fill;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != DEPTH)
                    fill <= fill + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage and read stage 1
    // ------------------------------------------------------------------
    logic [9:0] y_cur_q;
    logic [9:0] y_prev_q;

    // NOTE: the sample store has no reset; fill = 0 masks its contents, and
    // leaving it unreset lets it map onto block RAM. Same-cycle read returns old data.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= y_wr;
        y_cur_q  <= mem[addr_cur];
        y_prev_q <= mem[addr_prev];
    end

    logic        s1_on;
    logic        s1_prev_valid;
    logic [9:0]  s1_row;
    logic [11:0] s1_color;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_on         <= 1'b0;
            s1_prev_valid <= 1'b0;
            s1_row        <= '0;
            s1_color      <= '0;
        end else begin
            s1_on         <= enable && cur_valid;
            s1_prev_valid <= prev_valid;
            s1_row        <= vcount;
            s1_color      <= color;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: vertical-segment hit test and registered pixel
    // ------------------------------------------------------------------
    logic [9:0] y_prev_eff;
    logic [9:0] lo;
    logic [9:0] hi;
    logic       lit;

    always_comb begin
        y_prev_eff = s1_prev_valid ? y_prev_q : y_cur_q;
        lo         = (y_cur_q < y_prev_eff) ? y_cur_q : y_prev_eff;
        hi         = (y_cur_q < y_prev_eff) ? y_prev_eff : y_cur_q;
        lit        = s1_on && (s1_row >= lo) &&
                     ({2'b00, s1_row} < ({2'b00, hi} + 12'(THICKNESS)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pixel <= '0;
        else
            pixel <= lit ? s1_color : 12'h000;
    end

endmodule
